prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: WIDTH, 32, instruction word and memory address width.
REQ-002 Parameter: ADDR_WIDTH, 10, word-address bits of instruction memory; capacity 2**ADDR_WIDTH words.
REQ-003 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-high reset.
REQ-005 Port: rx_data  input  8  incoming stream byte.
REQ-006 Port: rx_valid  input  1  rx_data valid.
REQ-007 Port: rx_ready  output  1  loader can accept a byte.
REQ-008 Port: mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 Port: mem_addr  output  WIDTH  byte address of the word being written.
REQ-010 Port: mem_wdata  output  WIDTH  assembled instruction word.
REQ-011 Port: cpu_rst  output  1  holds the CPU in reset while loading.
REQ-012 Port: busy  output  1  load in progress.
REQ-013 Port: done  output  1  load completed successfully; sticky.
REQ-014 Port: err  output  1  load aborted; sticky.

Function
REQ-015 The loader SHALL accept a byte only on a rising edge where rx_valid and rx_ready are both high; no other byte is consumed.
REQ-016 Stream format SHALL be: count N (16 bits, little-endian, 2 bytes), then N words of 4 bytes each, little-endian (first byte = bits 7:0).
REQ-017 States SHALL be CNT_LO, CNT_HI, DATA, CSUM (macro only), DONE, ERR; reset state CNT_LO.
REQ-018 rx_ready SHALL be high in CNT_LO, CNT_HI, DATA, CSUM and low in DONE and ERR.
REQ-019 On accepting CNT_HI: N=0 -> DONE; N > 2**ADDR_WIDTH -> ERR with no write; otherwise -> DATA.
REQ-020 On the edge accepting a word's 4th byte, the loader SHALL register mem_we=1, mem_wdata=assembled word, mem_addr=word_index*4 (WIDTH bits, upper bits zero), visible for exactly one cycle.
REQ-021 word_index SHALL start at 0 and increment after each write; it SHALL never exceed N-1.
REQ-022 After the Nth word's write is registered, state SHALL go to DONE (no macro) or CSUM (macro) on the same edge.
REQ-023 Gaps in rx_valid SHALL stall assembly without altering partial word contents or index.
REQ-024 cpu_rst SHALL be registered, high from reset, and fall one clock after done first rises; it SHALL stay high in ERR.
REQ-025 busy SHALL be high in CNT_LO, CNT_HI, DATA, CSUM; done high only in DONE; err high only in ERR.
REQ-026 DONE and ERR SHALL be exited only by rst; rx_data/rx_valid ignored there.

Reset
REQ-027 rst high SHALL immediately force: state CNT_LO, rx_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, busy=1, done=0, err=0, index, count, byte counter and checksum cleared.
REQ-028 rst asserted mid-word or mid-count SHALL discard partial data; next stream starts at count byte and address 0.

Configuration
REQ-029 Macro LOADER_CHECKSUM_EN, when defined, SHALL add state CSUM: after the last word one extra byte is accepted and compared with the XOR of all word bytes (count bytes excluded); match -> DONE, mismatch -> ERR; N=0 also passes through CSUM expecting 0x00.
REQ-030 Without LOADER_CHECKSUM_EN no CSUM state or XOR logic SHALL exist and the last word leads directly to DONE.

Verification
REQ-031 Stream 02 00 13 05 10 00 93 05 20 00 -> mem_we pulses: addr 0x0 data 0x00100513, addr 0x4 data 0x00200593; done=1, cpu_rst=0 one cycle later (no macro).
REQ-032 Stream 00 00 -> done=1 after 2 accepted bytes, zero mem_we pulses, cpu_rst falls next cycle.
REQ-033 REQ-031 stream with random rx_valid-low gaps of 0-5 cycles -> identical write sequence and final state.
REQ-034 ADDR_WIDTH=10, stream 01 04 (N=1025) -> err=1, rx_ready=0, no mem_we, cpu_rst stays 1.
REQ-035 rst pulse after 6 bytes of REQ-031 stream, then full stream -> no write from partial data; writes at 0x0, 0x4 as in REQ-031.
REQ-036 LOADER_CHECKSUM_EN defined, REQ-031 stream plus B0 -> done=1; plus B1 -> both writes occur, then err=1, cpu_rst stays 1.

Source files
------------

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader: receives a byte stream (16-bit little-endian word count, then
// N little-endian 32-bit words) and writes each assembled word into
// instruction memory while holding the CPU in reset.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
//
// Handshake: a byte is consumed on a rising edge only when rx_valid and
// rx_ready are both high; rx_valid may drop at any time to stall the stream.
module prog_loader #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             cpu_rst,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
`ifdef LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_e;

    // Largest word count the memory can hold.
    localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

    // FSM state is a plain named register so checkers can bind to it.
    state_e                state;
    logic [7:0]            count_lo;
    logic [15:0]           count;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            byte_cnt;
    logic [23:0]           word_buf;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum;
`endif

    logic        accept;
    logic [31:0] new_count;
    logic        last_word;

    assign accept    = rx_valid && rx_ready;
    assign new_count = {16'd0, rx_data, count_lo};
    assign last_word = (32'(word_idx) + 32'd1) == 32'(count);

    // Status flags decode directly from the registered state.
    assign rx_ready = (state != DONE) && (state != ERR);
    assign busy     = (state != DONE) && (state != ERR);
    assign done     = (state == DONE);
    assign err      = (state == ERR);

    // Stream parser: count capture, word assembly, memory write strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CNT_LO;
            count_lo  <= '0;
            count     <= '0;
            word_idx  <= '0;
            byte_cnt  <= '0;
            word_buf  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst   <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            mem_we  <= 1'b0;
            // CPU is released one clock after the load is seen complete.
            cpu_rst <= (state != DONE);
            if (accept) begin
                case (state)
                    CNT_LO: begin
                        count_lo <= rx_data;
                        state    <= CNT_HI;
                    end
                    CNT_HI: begin
                        count <= {rx_data, count_lo};
                        if (new_count == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            state <= DONE;
`endif
                        end else if (new_count > MAX_WORDS) begin
                            state <= ERR;
                        end else begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                        if (byte_cnt != 2'd3) begin
                            word_buf[8*byte_cnt +: 8] <= rx_data;
                            byte_cnt                  <= byte_cnt + 2'd1;
                        end else begin
                            byte_cnt  <= 2'd0;
                            mem_we    <= 1'b1;
                            mem_wdata <= WIDTH'({rx_data, word_buf});
                            mem_addr  <= WIDTH'({word_idx, 2'b00});
                            if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= CSUM;
`else
                                state <= DONE;
`endif
                            end else begin
                                word_idx <= word_idx + 1'b1;
                            end
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    CSUM: begin
                        state <= (rx_data == csum) ? DONE : ERR;
                    end
`endif
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
// Directed bench for prog_loader with a write scoreboard.
module tb_prog_loader;

    localparam int WIDTH = 32;
    localparam int AW    = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             cpu_rst;
    logic             busy;
    logic             done;
    logic             err;

    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          wr_cnt  = 0;
    int          wr_base = 0;
    logic [63:0] exp_q[$];
    logic [31:0] words[0:1023];
    logic [7:0]  bench_csum;

    prog_loader #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_rst(cpu_rst), .busy(busy),
        .done(done), .err(err)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $error("FAIL unexpected_write observed=%0h_%0h expected=none", mem_addr, mem_wdata);
            end else begin
                check("write", {mem_addr, mem_wdata}, exp_q.pop_front());
            end
        end
    end

    // Drive one byte after an idle gap; wait (bounded) for the handshake.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!rx_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!rx_ready) check("rx_ready_timeout", rx_ready, 1);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    // Full stream from words[0..n-1]; expected writes queued as they are driven.
    task automatic send_stream(input int n, input int max_gap);
        logic [15:0] cnt;
        cnt        = 16'(n);
        bench_csum = 8'h00;
        send_byte(cnt[7:0], $urandom_range(0, max_gap));
        send_byte(cnt[15:8], $urandom_range(0, max_gap));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({32'(i * 4), words[i]});
            for (int b = 0; b < 4; b++) begin
                bench_csum = bench_csum ^ words[i][8*b +: 8];
                send_byte(words[i][8*b +: 8], $urandom_range(0, max_gap));
            end
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(bench_csum, $urandom_range(0, max_gap));
`endif
    endtask

    task automatic do_reset(input string tag);
        rx_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check({tag, "_rst_addr_data"}, {mem_addr, mem_wdata}, 64'd0);
        check({tag, "_rst_flags"}, {58'd0, rx_ready, mem_we, cpu_rst, busy, done, err}, 64'b101100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wr_base = wr_cnt;
    endtask

    // Completion: done this cycle with CPU still held, released the next.
    task automatic check_done(input string tag, input int n_writes);
        @(negedge clk);
        check({tag, "_done_flags"}, {58'd0, rx_ready, cpu_rst, busy, done, err}, 64'b01010);
        @(negedge clk);
        check({tag, "_cpu_rst_fall"}, cpu_rst, 0);
        check({tag, "_writes"}, 64'(wr_cnt - wr_base), 64'(n_writes));
        check({tag, "_queue_empty"}, 64'(exp_q.size()), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        check("por_addr_data", {mem_addr, mem_wdata}, 64'd0);
        check("por_flags", {58'd0, rx_ready, mem_we, cpu_rst, busy, done, err}, 64'b101100);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Two-word reference stream, back-to-back bytes.
        words[0] = 32'h0010_0513;
        words[1] = 32'h0020_0593;
        send_stream(2, 0);
        check_done("basic", 2);

        // Bytes offered while DONE are ignored.
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        check("done_sticky", {61'd0, done, rx_ready, cpu_rst}, 64'b100);
        check("done_no_writes", 64'(wr_cnt - wr_base), 2);

        // Empty program.
        do_reset("empty");
        send_stream(0, 0);
        check_done("empty", 0);

        // Reference stream with random valid gaps.
        do_reset("gaps");
        words[0] = 32'h0010_0513;
        words[1] = 32'h0020_0593;
        send_stream(2, 5);
        check_done("gaps", 2);

        // Count one past capacity: abort without writing.
        do_reset("oversize");
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        @(negedge clk);
        check("oversize_flags", {59'd0, rx_ready, busy, done, err, cpu_rst}, 64'b00011);
        repeat (3) @(negedge clk);
        check("oversize_cpu_rst", cpu_rst, 1);
        check("oversize_writes", 64'(wr_cnt - wr_base), 0);

        // Reset mid-word discards partial data.
        do_reset("midword");
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'h10, 0);
        send_byte(8'h00, 0);
        do_reset("restart");
        words[0] = 32'h0010_0513;
        words[1] = 32'h0020_0593;
        send_stream(2, 0);
        check_done("restart", 2);

        // Short random program with gaps.
        do_reset("rand3");
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        send_stream(3, 2);
        check_done("rand3", 3);

        // Exactly full memory: last write at the top word address.
        do_reset("full");
        for (int i = 0; i < 1024; i++) words[i] = $urandom;
        send_stream(1024, 0);
        check_done("full", 1024);

`ifdef LOADER_CHECKSUM_EN
        // Bad checksum: writes still happen, then abort.
        do_reset("badsum");
        words[0] = 32'h0010_0513;
        words[1] = 32'h0020_0593;
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({32'(i * 4), words[i]});
            for (int b = 0; b < 4; b++) send_byte(words[i][8*b +: 8], 0);
        end
        send_byte(8'hB1, 0);
        repeat (2) @(negedge clk);
        check("badsum_flags", {60'd0, done, err, cpu_rst, rx_ready}, 64'b0110);
        check("badsum_writes", 64'(wr_cnt - wr_base), 2);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
